// File: rtl/cve2_compressed_encoder.sv
// Compresses eligible RV32 instructions to RVC and packs the 16/32-bit results into 32-bit words.
// Define CVE2_COMPRESS_SP_EN to also emit c.lwsp/c.swsp; otherwise those forms pass through as 32 bits.
module cve2_compressed_encoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o
);

  typedef enum logic [1:0] {EMPTY, HALF, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [15:0] residue_q, residue_d;
  logic [31:0] data_d;
  logic        valid_d, last_d;
  logic [16:0] cmp;
  logic        is16;
  logic [15:0] c16;
  logic        can_load, in_fire;

  // Returns {eligible, rvc}; eligible=0 means the instruction must stay 32 bits wide.
  function automatic logic [16:0] compress(input logic [31:0] i);
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm_i, imm_s;
    logic        imm_i_small;
    op          = i[6:0];
    rd          = i[11:7];
    f3          = i[14:12];
    rs1         = i[19:15];
    rs2         = i[24:20];
    imm_i       = i[31:20];
    imm_s       = {i[31:25], i[11:7]};
    imm_i_small = (imm_i[11:5] == {7{imm_i[5]}});
    compress    = '0;
    if (i == 32'h0000_0013) begin
      compress = {1'b1, 16'h0001};
    end else if (i == 32'h0010_0073) begin
      compress = {1'b1, 16'h9002};
    end else if (op == 7'b0010011 && f3 == 3'b000 && imm_i_small) begin
      if (rd != 5'd0 && rd == rs1 && imm_i != 12'd0)
        compress = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      else if (rd != 5'd0 && rs1 == 5'd0)
        compress = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (op == 7'b0110011 && f3 == 3'b000 && i[31:25] == 7'd0 &&
                 rd != 5'd0 && rs2 != 5'd0) begin
      if (rs1 == 5'd0)
        compress = {1'b1, 4'b1000, rd, rs2, 2'b10};
      else if (rs1 == rd)
        compress = {1'b1, 4'b1001, rd, rs2, 2'b10};
    end else if (op == 7'b1100111 && f3 == 3'b000 && imm_i == 12'd0 &&
                 rs1 != 5'd0 && rd[4:1] == 4'd0) begin
      // rd[0] selects c.jalr (link to x1) versus c.jr (x0)
      compress = {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
    end else if (op == 7'b0000011 && f3 == 3'b010) begin
      if (rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 && imm_i[11:7] == 5'd0 && imm_i[1:0] == 2'b00)
        compress = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
`ifdef CVE2_COMPRESS_SP_EN
      else if (rd != 5'd0 && rs1 == 5'd2 && imm_i[11:8] == 4'd0 && imm_i[1:0] == 2'b00)
        compress = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
`endif
    end else if (op == 7'b0100011 && f3 == 3'b010) begin
      if (rs2[4:3] == 2'b01 && rs1[4:3] == 2'b01 && imm_s[11:7] == 5'd0 && imm_s[1:0] == 2'b00)
        compress = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
`ifdef CVE2_COMPRESS_SP_EN
      else if (rs1 == 5'd2 && imm_s[11:8] == 4'd0 && imm_s[1:0] == 2'b00)
        compress = {1'b1, 3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
`endif
    end
  endfunction

  always_comb begin
    cmp  = compress(in_instr_i);
    is16 = (in_instr_i[1:0] != 2'b11) || cmp[16];
    c16  = (in_instr_i[1:0] != 2'b11) ? in_instr_i[15:0] : cmp[15:0];
  end

  assign can_load   = !out_valid_o || out_ready_i;
  assign in_ready_o = can_load && (state_q != FLUSH);
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    state_d   = state_q;
    residue_d = residue_q;
    data_d    = out_data_o;
    last_d    = out_last_o;
    valid_d   = out_valid_o && !out_ready_i;
    if (state_q == FLUSH) begin
      if (can_load) begin
        data_d  = {16'h0001, residue_q};
        last_d  = 1'b1;
        valid_d = 1'b1;
        state_d = EMPTY;
      end
    end else if (in_fire) begin
      case (state_q)
        EMPTY: begin
          if (!is16) begin
            data_d  = in_instr_i;
            last_d  = in_last_i;
            valid_d = 1'b1;
          end else if (in_last_i) begin
            // a lone trailing halfword is padded with c.nop
            data_d  = {16'h0001, c16};
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            residue_d = c16;
            state_d   = HALF;
          end
        end
        HALF: begin
          valid_d = 1'b1;
          if (is16) begin
            data_d  = {c16, residue_q};
            last_d  = in_last_i;
            state_d = EMPTY;
          end else begin
            data_d    = {in_instr_i[15:0], residue_q};
            residue_d = in_instr_i[31:16];
            last_d    = 1'b0;
            state_d   = in_last_i ? FLUSH : HALF;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      residue_q   <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      out_data_o  <= '0;
    end else begin
      state_q     <= state_d;
      residue_q   <= residue_d;
      out_valid_o <= valid_d;
      out_last_o  <= last_d;
      out_data_o  <= data_d;
    end
  end

endmodule

// File: tb/tb_cve2_compressed_encoder.sv
// Bench for cve2_compressed_encoder: directed packet scenarios plus randomized traffic against a halfword-queue model.
module tb_cve2_compressed_encoder;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_instr;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] hq[$];
  logic [32:0] exp_q[$];

  cve2_compressed_encoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_instr_i (in_instr),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference RVC encoder: decode mnemonic fields to integers, then assemble the halfword arithmetically.
  function automatic logic [16:0] ref_c(input logic [31:0] w);
    int op, rd, rs1, rs2, f3, f7, imm, simm, code;
    op   = int'(w[6:0]);
    rd   = int'(w[11:7]);
    f3   = int'(w[14:12]);
    rs1  = int'(w[19:15]);
    rs2  = int'(w[24:20]);
    f7   = int'(w[31:25]);
    imm  = int'($signed(w[31:20]));
    simm = int'($signed({w[31:25], w[11:7]}));
    code = -1;
    if (w == 32'h0000_0013) code = 'h0001;
    else if (w == 32'h0010_0073) code = 'h9002;
    else if (op == 'h13 && f3 == 0 && imm >= -32 && imm <= 31) begin
      if (rd != 0 && rd == rs1 && imm != 0)
        code = (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1;
      else if (rd != 0 && rs1 == 0)
        code = (2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | ((imm & 31) << 2) | 1;
    end else if (op == 'h33 && f3 == 0 && f7 == 0 && rd != 0 && rs2 != 0) begin
      if (rs1 == 0) code = 'h8002 | (rd << 7) | (rs2 << 2);
      else if (rs1 == rd) code = 'h9002 | (rd << 7) | (rs2 << 2);
    end else if (op == 'h67 && f3 == 0 && imm == 0 && rs1 != 0 && (rd == 0 || rd == 1)) begin
      code = ((rd == 1) ? 'h9002 : 'h8002) | (rs1 << 7);
    end else if (op == 'h03 && f3 == 2 && imm >= 0 && imm % 4 == 0) begin
      if (rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 && imm <= 124)
        code = (2 << 13) | (((imm >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((imm >> 2) & 1) << 6)
             | (((imm >> 6) & 1) << 5) | ((rd - 8) << 2);
`ifdef CVE2_COMPRESS_SP_EN
      else if (rd != 0 && rs1 == 2 && imm <= 252)
        code = (2 << 13) | (((imm >> 5) & 1) << 12) | (rd << 7) | (((imm >> 2) & 7) << 4)
             | (((imm >> 6) & 3) << 2) | 2;
`endif
    end else if (op == 'h23 && f3 == 2 && simm >= 0 && simm % 4 == 0) begin
      if (rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15 && simm <= 124)
        code = (6 << 13) | (((simm >> 3) & 7) << 10) | ((rs1 - 8) << 7) | (((simm >> 2) & 1) << 6)
             | (((simm >> 6) & 1) << 5) | ((rs2 - 8) << 2);
`ifdef CVE2_COMPRESS_SP_EN
      else if (rs1 == 2 && simm <= 252)
        code = (6 << 13) | (((simm >> 2) & 15) << 9) | (((simm >> 6) & 3) << 7) | (rs2 << 2) | 2;
`endif
    end
    ref_c = (code < 0) ? 17'd0 : {1'b1, 16'(code)};
  endfunction

  // Packet model: a stream of halfwords, emitted two at a time, padded with c.nop at packet end.
  task automatic model_accept(input logic [31:0] w, input logic lst);
    logic [16:0] r;
    logic [15:0] lo, hi;
    if (w[1:0] != 2'b11) hq.push_back(w[15:0]);
    else begin
      r = ref_c(w);
      if (r[16]) hq.push_back(r[15:0]);
      else begin
        hq.push_back(w[15:0]);
        hq.push_back(w[31:16]);
      end
    end
    while (hq.size() >= 2) begin
      lo = hq.pop_front();
      hi = hq.pop_front();
      exp_q.push_back({lst && (hq.size() == 0), hi, lo});
    end
    if (lst && hq.size() == 1) begin
      lo = hq.pop_front();
      exp_q.push_back({1'b1, 16'h0001, lo});
    end
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0:       pick_reg = int'($urandom_range(0, 31));
      1:       pick_reg = int'($urandom_range(0, 2));
      default: pick_reg = int'($urandom_range(8, 15));
    endcase
  endfunction

  function automatic logic [31:0] i_type(int imm, int rs1, int f3, int rd, int op);
    i_type = 32'((imm & 'hfff) << 20) | 32'(rs1 << 15) | 32'(f3 << 12) | 32'(rd << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] s_type(int imm, int rs2, int rs1, int f3, int op);
    s_type = 32'(((imm >> 5) & 'h7f) << 25) | 32'(rs2 << 20) | 32'(rs1 << 15) | 32'(f3 << 12)
           | 32'((imm & 31) << 7) | 32'(op);
  endfunction

  function automatic int ls_imm();
    ls_imm = int'($urandom_range(0, 70)) * 4 - 8;
    if ($urandom_range(0, 5) == 0) ls_imm = ls_imm + 1 + int'($urandom_range(0, 2));
  endfunction

  function automatic logic [31:0] gen_instr();
    int rd, rs1, rs2, imm, f7;
    logic [31:0] w;
    rd  = pick_reg();
    rs1 = pick_reg();
    rs2 = pick_reg();
    w   = $urandom();
    case ($urandom_range(0, 8))
      0, 8: w[1:0] = 2'b11;
      1: w[1:0] = 2'($urandom_range(0, 2));
      2: begin
        if ($urandom_range(0, 1) == 1) rs1 = rd;
        else if ($urandom_range(0, 1) == 1) rs1 = 0;
        imm = int'($urandom_range(0, 80)) - 40;
        w = i_type(imm, rs1, 0, rd, 'h13);
      end
      3: begin
        f7 = ($urandom_range(0, 4) == 0) ? 32 : 0;
        if ($urandom_range(0, 1) == 1) rs1 = rd;
        else if ($urandom_range(0, 1) == 1) rs1 = 0;
        w = 32'(f7 << 25) | 32'(rs2 << 20) | 32'(rs1 << 15) | 32'(rd << 7) | 32'h33;
      end
      4: begin
        if ($urandom_range(0, 2) == 0) rs1 = 2;
        w = i_type(ls_imm(), rs1, 2, rd, 'h03);
      end
      5: begin
        if ($urandom_range(0, 2) == 0) rs1 = 2;
        w = s_type(ls_imm(), rs2, rs1, 2, 'h23);
      end
      6: begin
        rd  = ($urandom_range(0, 3) == 0) ? pick_reg() : int'($urandom_range(0, 1));
        imm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) - 4 : 0;
        w = i_type(imm, rs1, 0, rd, 'h67);
      end
      default: begin
        case ($urandom_range(0, 3))
          0:       w = 32'h0000_0013;
          1:       w = 32'h0010_0073;
          2:       w = 32'h0040_006F;
          default: w = 32'h0000_1517;
        endcase
      end
    endcase
    gen_instr = w;
  endfunction

  // Presents one instruction until accepted; returns at 1 time unit after the accepting edge.
  task automatic push(input logic [31:0] ins, input logic lst, output bit to);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_last  = lst;
    to       = 1'b0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) to = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h last=%b required 0/00000000/0", out_valid, out_data, out_last);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_pack_pair();
    bit to;
    push(32'h0014_0413, 1'b0, to);
    checks++;
    if (to || out_valid !== 1'b0) begin errors++; $display("FAIL pair_first got valid=%b timeout=%b required 0/0", out_valid, to); end
    push(32'h00B0_0533, 1'b1, to);
    checks++;
    if (to || out_valid !== 1'b1 || out_data !== 32'h852E_0405 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL pair_word got valid=%b data=%h last=%b required 1/852e0405/1", out_valid, out_data, out_last);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_drain got valid=%b required=0", out_valid); end
  endtask

  task automatic test_passthrough();
    bit to;
    push(32'h0040_006F, 1'b1, to);
    checks++;
    if (to || out_valid !== 1'b1 || out_data !== 32'h0040_006F || out_last !== 1'b1) begin
      errors++;
      $display("FAIL jal_pass got valid=%b data=%h last=%b required 1/0040006f/1", out_valid, out_data, out_last);
    end
    step();
  endtask

  task automatic test_flush();
    bit to;
    push(32'h0014_0413, 1'b0, to);
    push(32'h0040_006F, 1'b1, to);
    checks++;
    if (to || out_data !== 32'h006F_0405 || out_last !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_first got valid=%b data=%h last=%b required 1/006f0405/0", out_valid, out_data, out_last);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b required=0", in_ready); end
    step();
    checks++;
    if (out_data !== 32'h0001_0040 || out_last !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_word got valid=%b data=%h last=%b required 1/00010040/1", out_valid, out_data, out_last);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done got valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_sp_forms();
    bit to;
    logic [31:0] want;
`ifdef CVE2_COMPRESS_SP_EN
    want = 32'h0001_4492;
`else
    want = 32'h0041_2483;
`endif
    push(32'h0041_2483, 1'b1, to);
    checks++;
    if (to || out_valid !== 1'b1 || out_data !== want || out_last !== 1'b1) begin
      errors++;
      $display("FAIL lwsp got valid=%b data=%h last=%b required 1/%h/1", out_valid, out_data, out_last, want);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit to;
    out_ready = 1'b0;
    push(32'h0040_006F, 1'b1, to);
    in_valid = 1'b1; in_instr = 32'h00B0_0533; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || out_valid !== 1'b1 || out_data !== 32'h0040_006F || out_last !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d got valid=%b data=%h last=%b ready=%b required 1/0040006f/1/0",
                 i, out_valid, out_data, out_last, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b required=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0001_852E || out_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_next got valid=%b data=%h last=%b required 1/0001852e/1", out_valid, out_data, out_last);
    end
    step();
  endtask

  task automatic test_reset_mid_packet();
    bit to;
    push(32'h0014_0413, 1'b0, to);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b required=0", out_valid); end
    end
    rst_n = 1'b1;
    push(32'h0040_006F, 1'b1, to);
    checks++;
    if (to || out_valid !== 1'b1 || out_data !== 32'h0040_006F || out_last !== 1'b1) begin
      errors++;
      $display("FAIL midrst_word got valid=%b data=%h last=%b required 1/0040006f/1", out_valid, out_data, out_last);
    end
    step();
  endtask

  task automatic test_random();
    logic [32:0] e;
    bit done = 1'b0;
    int words = 0;
    hq.delete();
    exp_q.delete();
    for (int k = 0; k < 3400; k++) begin
      if (k < 3000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_instr  = gen_instr();
        in_last   = ($urandom_range(0, 4) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if (done && exp_q.size() == 0 && !out_valid) break;
        in_valid  = !done;
        in_instr  = 32'h0040_006F;
        in_last   = 1'b1;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        words++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra got data=%h last=%b required no word", out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL rand_word n=%0d got data=%h last=%b required data=%h last=%b",
                     words, out_data, out_last, e[31:0], e[32]);
          end
        end
      end
      if (in_valid && in_ready) begin
        model_accept(in_instr, in_last);
        if (k >= 3000) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || hq.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain got pending=%0d residue=%0d valid=%b required 0/0/0", exp_q.size(), hq.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pack_pair();
    test_passthrough();
    test_flush();
    test_sp_forms();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_compressed_encoder.md
CVE2_COMPRESSED_ENCODER -- requirements
Module: cve2_compressed_encoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk_i input 1, rising-edge clock; rst_ni input 1, reset asserted low, sampled on clk_i.
REQ-002 in_valid_i  input  1  input instruction valid.
REQ-003 in_ready_o  output  1  encoder accepts the input instruction this cycle.
REQ-004 in_instr_i  input  32  RV32 instruction; if [1:0]!=2'b11, the input is already compressed and only [15:0] are used.
REQ-005 in_last_i  input  1  the instruction is the last of its packet; flush the packer after it.
REQ-006 out_valid_o  output  1  packed word valid.
REQ-007 out_ready_i  input  1  downstream accepts out_data_o.
REQ-008 out_data_o  output  32  packed word: halfword 0 in [15:0], halfword 1 in [31:16].
REQ-009 out_last_o  output  1  final word of the packet.

Function
REQ-010 Input transfer SHALL occur when in_valid_i&&in_ready_o; output transfer SHALL occur when out_valid_o&&out_ready_i.
REQ-011 in_ready_o SHALL be (!out_valid_o||out_ready_i)&&(state!=FLUSH).
REQ-012 Outputs SHALL be registered: a word produced by an input transfer SHALL appear on out_data_o the following cycle.
REQ-013 The encoder SHALL compress an instruction (opcode [1:0]==2'b11) to 16 bits for exactly these forms:
- c.nop: addi x0,x0,0 -> 0x0001.
- c.addi: addi rd=rs1!=0, imm!=0, imm in [-32,31].
- c.li: addi rd!=0, rs1=x0, imm in [-32,31].
- c.mv: add rd!=0, rs1=x0, rs2!=0.
- c.add: add rd=rs1!=0, rs2!=0.
- c.lw/c.sw: rd/rs2 and rs1 in x8..x15, offset a multiple of 4 in [0,124].
- c.jr: jalr x0, rs1!=0, imm 0.
- c.jalr: jalr x1, rs1!=0, imm 0.
- c.ebreak: 0x00100073 -> 0x9002.
REQ-014 Compressed encodings SHALL be bit-exact RVC, so the RVC decoder maps each one back to the identical 32-bit instruction.
REQ-015 All other 32-bit instructions, including PC-relative branch, jal, auipc and every other form, SHALL pass unchanged as 32 bits.
REQ-016 The FSM SHALL have states EMPTY (no residue), HALF (16-bit residue register valid) and FLUSH (residue pending final output).
REQ-017 EMPTY+16b SHALL set residue<=c16 and go to HALF, with no output; if in_last_i, it SHALL instead output {16'h0001,c16} with out_last_o=1 and stay in EMPTY.
REQ-018 EMPTY+32b SHALL output the instruction with out_last_o=in_last_i and stay in EMPTY.
REQ-019 HALF+16b SHALL output {c16,residue} with out_last_o=in_last_i and go to EMPTY.
REQ-020 HALF+32b SHALL output {instr[15:0],residue}, set residue<=instr[31:16], and then:
- stay in HALF if !in_last_i;
- if in_last_i, clear out_last_o and go to FLUSH.
REQ-021 FLUSH SHALL output {16'h0001,residue} with out_last_o=1 once the output register is free, then go to EMPTY.
REQ-022 While out_valid_o&&!out_ready_i, out_data_o and out_last_o SHALL hold stable, and the residue and state SHALL not change.

Reset
REQ-023 While rst_ni=0 at a clk_i edge: state<=EMPTY, out_valid_o<=0, out_last_o<=0, out_data_o<=0, residue<=0; in_ready_o SHALL read 1 after reset.
REQ-024 Reset mid-packet SHALL discard the residue and any pending output word, with no flush.

Configuration
REQ-025 With CVE2_COMPRESS_SP_EN defined, c.lwsp (lw rd!=0, rs1=x2) and c.swsp (sw rs1=x2) SHALL be compressed for offsets that are a multiple of 4 in [0,252].
REQ-026 Without CVE2_COMPRESS_SP_EN, these forms SHALL pass as 32 bits, and no SP-form logic SHALL be synthesized.

Verification
REQ-027 Inputs 0x00140413 then 0x00B00533 (last) -> one word 0x852E0405, out_last_o=1, 1-cycle latency.
REQ-028 EMPTY, input 0x0040006F (jal, last) -> 0x0040006F passed verbatim, out_last_o=1.
REQ-029 Inputs 0x00140413 then 0x0040006F (last) -> 0x006F0405 (last=0), then 0x00010040 (last=1); in_ready_o=0 during FLUSH.
REQ-030 Input 0x00412483 (lw x9,4(x2), last): with CVE2_COMPRESS_SP_EN -> 0x00014492; without -> 0x00412483.
REQ-031 Hold out_ready_i=0 for 5 cycles with a word pending -> out_data_o stable, in_ready_o=0, and no input is lost after release.
REQ-032 Assert rst_ni=0 while in HALF with residue 0x0405 -> next word after reset contains no 0x0405, and out_valid_o=0 during reset.
